// File: rtl/trigger_sched_pkg.sv
// trigger_sched_pkg: shared FSM state type and default widths for the trigger window scheduler
package trigger_sched_pkg;
    localparam int CNT_W_DEF = 10;
    localparam int ID_W_DEF = 12;
    localparam int DROP_W = 16;
    typedef enum logic [2:0] {IDLE, WAIT_LAT, OPEN, REQ, DEAD} state_t;
endpackage

// File: rtl/trigger_pending_fifo.sv
// trigger_pending_fifo: pending-trigger timestamp queue; a pop frees space for a push in the same cycle
module trigger_pending_fifo #(
    parameter int W = 12,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = level == DEPTH[AW:0];
    assign empty = level == '0;
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
        end else begin
            wptr <= do_push ? wptr + 1'b1 : wptr;
            rptr <= do_pop ? rptr + 1'b1 : rptr;
            level <= (do_push && !do_pop) ? level + 1'b1 : (do_pop && !do_push) ? level - 1'b1 : level;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/trigger_window_scheduler.sv
// trigger_window_scheduler: queues trigger timestamps and sequences latency, capture window, readout handshake and deadtime
module trigger_window_scheduler
    import trigger_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ID_W = ID_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_trigger,
    input  logic                          trig_pulse,
    input  logic [CNT_W-1:0]              cfg_latency,
    input  logic [CNT_W-1:0]              cfg_window,
    input  logic [CNT_W-1:0]              cfg_deadtime,
    output logic                          window_gate,
    output logic                          rd_req,
    input  logic                          rd_ack,
    output logic [ID_W-1:0]               rd_trig_id,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_count
);
    state_t state;
    logic [CNT_W-1:0] cnt, win_r, dead_r, win_m1;
    logic [ID_W-1:0] ts, id_r, head;
    logic push, pop, full, empty, drop;
    assign push = trig_pulse & enable_trigger;
    assign pop = (state == IDLE) & ~empty;
    assign drop = push & full & ~pop;
    assign win_m1 = (cfg_window == '0) ? '0 : cfg_window - 1'b1;
    assign busy = (state != IDLE) | ~empty;
    trigger_pending_fifo #(.W(ID_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .din(ts),
        .dout(head),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            win_r <= '0;
            dead_r <= '0;
            ts <= '0;
            id_r <= '0;
            window_gate <= 1'b0;
            rd_req <= 1'b0;
            rd_trig_id <= '0;
            drop_count <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
            case (state)
                IDLE: if (!empty) begin
                    id_r <= head;
                    win_r <= win_m1;
                    dead_r <= cfg_deadtime;
                    if (cfg_latency == '0) begin
                        state <= OPEN;
                        cnt <= win_m1;
                        window_gate <= 1'b1;
                    end else begin
                        state <= WAIT_LAT;
                        cnt <= cfg_latency - 1'b1;
                    end
                end
                WAIT_LAT: if (cnt == '0) begin
                    state <= OPEN;
                    cnt <= win_r;
                    window_gate <= 1'b1;
                end else cnt <= cnt - 1'b1;
                OPEN: if (cnt == '0) begin
                    state <= REQ;
                    window_gate <= 1'b0;
                    rd_req <= 1'b1;
                    rd_trig_id <= id_r;
                end else cnt <= cnt - 1'b1;
                REQ: if (rd_ack) begin
                    rd_req <= 1'b0;
                    state <= (dead_r == '0) ? IDLE : DEAD;
                    cnt <= dead_r - 1'b1;
                end
                DEAD: if (cnt == '0) state <= IDLE;
                      else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trigger_window_scheduler.sv
// tb_trigger_window_scheduler: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_trigger_window_scheduler;
    logic clk = 0, rst_n = 0, enable_trigger = 0, trig_pulse = 0, rd_ack = 0;
    logic [9:0] cfg_latency = 0, cfg_window = 0, cfg_deadtime = 0;
    logic window_gate, rd_req, busy;
    logic [11:0] rd_trig_id, tb_ts, hid;
    logic [2:0] fifo_level;
    logic [15:0] drop_count;
    int total = 0, bad = 0, gcnt = 0;
    logic [11:0] exp_id[$];
    int exp_win[$];

    trigger_window_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable_trigger(enable_trigger), .trig_pulse(trig_pulse),
        .cfg_latency(cfg_latency), .cfg_window(cfg_window), .cfg_deadtime(cfg_deadtime),
        .window_gate(window_gate), .rd_req(rd_req), .rd_ack(rd_ack), .rd_trig_id(rd_trig_id),
        .busy(busy), .fifo_level(fifo_level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_ts <= 0;
        else tb_ts <= tb_ts + 1'b1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic pulse(input bit acc);
        trig_pulse = 1;
        if (acc) begin
            exp_id.push_back(tb_ts);
            exp_win.push_back(cfg_window == 0 ? 1 : int'(cfg_window));
        end
        @(negedge clk);
        trig_pulse = 0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) @(negedge clk);
        chk("idle_timeout", busy, 0);
    endtask

    // Monitor: measures each window's length and checks the ID of every completed handshake
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) gcnt = 0;
        else begin
            if (window_gate) gcnt++;
            else if (gcnt != 0) begin
                if (exp_win.size() == 0) chk("win_unexpected", exp_win.size(), 1);
                else chk("win_len", gcnt, exp_win.pop_front());
                gcnt = 0;
            end
            if (rd_req && rd_ack) begin
                if (exp_id.size() == 0) chk("id_unexpected", exp_id.size(), 1);
                else chk("rd_trig_id", rd_trig_id, exp_id.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        repeat (3) @(negedge clk);
        chk("rst_gate", window_gate, 0);
        chk("rst_req", rd_req, 0);
        chk("rst_id", rd_trig_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_count, 0);
        rst_n = 1;
        enable_trigger = 1;
        repeat (3) @(negedge clk);

        // 1) L=3 W=4 D=2, ack tied high
        cfg_latency = 3; cfg_window = 4; cfg_deadtime = 2; rd_ack = 1;
        pulse(1);
        for (int j = 1; j <= 14; j++) begin
            chk("t1_gate", window_gate, (j >= 5 && j <= 8));
            chk("t1_req", rd_req, (j == 9));
            if (j == 1) chk("t1_level_push", fifo_level, 1);
            if (j == 2) chk("t1_level_pop", fifo_level, 0);
            if (j == 11) chk("t1_busy_dead", busy, 1);
            if (j == 12) chk("t1_busy_idle", busy, 0);
            @(negedge clk);
        end

        // 2) L=0 W=0 D=0
        cfg_latency = 0; cfg_window = 0; cfg_deadtime = 0;
        pulse(1);
        for (int j = 1; j <= 6; j++) begin
            chk("t2_gate", window_gate, (j == 2));
            chk("t2_req", rd_req, (j == 3));
            if (j == 4) chk("t2_busy", busy, 0);
            @(negedge clk);
        end

        // 3) queue overflow: 7 back-to-back pulses, last 2 dropped
        cfg_latency = 20; cfg_window = 2; cfg_deadtime = 1;
        for (int k = 0; k < 7; k++) pulse(k < 5);
        chk("t3_level", fifo_level, 4);
        chk("t3_drop", drop_count, 2);
        wait_idle(1000);
        chk("t3_drained_id", exp_id.size(), 0);

        // 4) ack withheld 50 cycles with a second trigger queued
        cfg_latency = 1; cfg_window = 1; cfg_deadtime = 1; rd_ack = 0;
        hid = tb_ts;
        pulse(1);
        for (int i = 0; i < 100 && !rd_req; i++) @(negedge clk);
        chk("t4_req_timeout", rd_req, 1);
        pulse(1);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            if (!rd_req || rd_trig_id !== hid || window_gate) viol++;
            @(negedge clk);
        end
        chk("t4_hold_stable", viol, 0);
        chk("t4_level", fifo_level, 1);
        rd_ack = 1;
        wait_idle(200);
        chk("t4_drained", exp_id.size(), 0);

        // 5) reset during OPEN with 2 queued
        cfg_latency = 2; cfg_window = 10; cfg_deadtime = 0;
        for (int k = 0; k < 3; k++) pulse(1);
        for (int i = 0; i < 100 && !window_gate; i++) @(negedge clk);
        chk("t5_gate_open", window_gate, 1);
        chk("t5_level_pre", fifo_level, 2);
        chk("t5_drop_pre", drop_count, 2);
        rst_n = 0;
        exp_id.delete();
        exp_win.delete();
        #1;
        chk("t5_gate", window_gate, 0);
        chk("t5_req", rd_req, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_drop", drop_count, 0);
        @(negedge clk);
        rst_n = 1;
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            if (window_gate || rd_req || busy) viol++;
            @(negedge clk);
        end
        chk("t5_quiet", viol, 0);

        // 6) enable_trigger=0 blocks new pulses but queued work completes
        cfg_latency = 1; cfg_window = 2; cfg_deadtime = 1;
        for (int k = 0; k < 3; k++) pulse(1);
        enable_trigger = 0;
        for (int k = 0; k < 3; k++) pulse(0);
        chk("t6_level", fifo_level, 2);
        chk("t6_drop", drop_count, 0);
        wait_idle(300);
        repeat (3) @(negedge clk);
        chk("t6_ids_done", exp_id.size(), 0);
        chk("t6_wins_done", exp_win.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
